// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch (I) and data access (D).
// Serialises fixed-latency accesses, returns registered data with one-cycle ready pulses.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_data,
  output logic              i_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

  localparam logic [2:0] LatCnt = 3'(MEM_LATENCY);

  state_e            state_q;
  logic [2:0]        count_q;
  logic              last_d_q;
  logic [DATA_W-1:0] i_data_q, d_rdata_q, mem_wdata_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              i_ready_q, d_ready_q, mem_read_q, mem_write_q;
  logic              grant_d, grant_i;

  // D wins unless the previous grant was D and a fetch is waiting.
  always_comb begin
    grant_d = d_req & (~i_req | ~last_d_q);
    grant_i = i_req & ~grant_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      count_q     <= 3'd0;
      last_d_q    <= 1'b0;
      i_data_q    <= '0;
      d_rdata_q   <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (grant_d || grant_i) begin
            mem_addr_q  <= grant_d ? d_addr : i_addr;
            if (grant_d) mem_wdata_q <= d_wdata;
            mem_read_q  <= grant_i | ~d_we;
            mem_write_q <= grant_d & d_we;
            count_q     <= 3'd1;
            last_d_q    <= grant_d;
            state_q     <= grant_d ? StBusyD : StBusyI;
          end
        end
        StBusyI, StBusyD: begin
          if (count_q == LatCnt) begin
            if (state_q == StBusyI) begin
              i_data_q  <= mem_rdata;
              i_ready_q <= 1'b1;
            end else begin
              // Stores leave the last load value untouched.
              if (mem_read_q) d_rdata_q <= mem_rdata;
              d_ready_q <= 1'b1;
            end
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            state_q     <= StIdle;
          end else begin
            count_q <= count_q + 3'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign i_data    = i_data_q;
  assign d_rdata   = d_rdata_q;
  assign i_ready   = i_ready_q;
  assign d_ready   = d_ready_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign stall_if  = i_req & ~i_ready_q;
  assign stall_mem = d_req & ~d_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three lanes (latency 2, 1, 7), each with its own memory model,
// checked by vector table, hand sequences and a transaction-level random reference model.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        i_req[3], d_req[3], d_we[3];
  logic [15:0] i_addr[3], d_addr[3], d_wdata[3];
  logic [15:0] i_data[3], d_rdata[3], mem_addr[3], mem_wdata[3], mem_rdata[3];
  logic        i_ready[3], d_ready[3], mem_read[3], mem_write[3], stall_if[3], stall_mem[3];

  int checks = 0;
  int errors = 0;
  logic [15:0] ref_mem [3][256];

  function automatic logic [15:0] mem_init(input logic [15:0] a);
    return 16'h6A05 + a - 16'h0010;
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : 7;
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g_lane
    localparam int unsigned Lat = (k == 0) ? 2 : (k == 1) ? 1 : 7;
    logic [15:0]  wmem [256];
    logic [255:0] written = '0;
    logic [2:0]   age = '0;

    // Memory model: data is only valid in the last cycle of the read window.
    always @(posedge clk) begin
      age <= mem_read[k] ? age + 3'd1 : 3'd0;
      if (mem_write[k]) begin
        wmem[mem_addr[k][7:0]]    <= mem_wdata[k];
        written[mem_addr[k][7:0]] <= 1'b1;
      end
    end
    assign mem_rdata[k] = (mem_read[k] && age == 3'(Lat - 1)) ?
        (written[mem_addr[k][7:0]] ? wmem[mem_addr[k][7:0]] : mem_init(mem_addr[k])) : 16'hDEAD;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LATENCY(Lat)) u_dut (
      .clk(clk), .reset_n(reset_n),
      .i_req(i_req[k]), .i_addr(i_addr[k]), .i_data(i_data[k]), .i_ready(i_ready[k]),
      .d_req(d_req[k]), .d_we(d_we[k]), .d_addr(d_addr[k]), .d_wdata(d_wdata[k]),
      .d_rdata(d_rdata[k]), .d_ready(d_ready[k]),
      .mem_read(mem_read[k]), .mem_write(mem_write[k]), .mem_addr(mem_addr[k]),
      .mem_wdata(mem_wdata[k]), .mem_rdata(mem_rdata[k]),
      .stall_if(stall_if[k]), .stall_mem(stall_mem[k])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input int k, input string tag);
    chk($sformatf("%s L%0d i_data", tag, k), i_data[k], 0);
    chk($sformatf("%s L%0d d_rdata", tag, k), d_rdata[k], 0);
    chk($sformatf("%s L%0d i_ready", tag, k), i_ready[k], 0);
    chk($sformatf("%s L%0d d_ready", tag, k), d_ready[k], 0);
    chk($sformatf("%s L%0d mem_read", tag, k), mem_read[k], 0);
    chk($sformatf("%s L%0d mem_write", tag, k), mem_write[k], 0);
    chk($sformatf("%s L%0d mem_addr", tag, k), mem_addr[k], 0);
    chk($sformatf("%s L%0d mem_wdata", tag, k), mem_wdata[k], 0);
  endtask

  task automatic do_reset();
    for (int k = 0; k < 3; k++) begin
      i_req[k] = 1'b0;
      d_req[k] = 1'b0;
    end
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  typedef struct {
    int          lane;
    bit          is_d;
    bit          we;
    bit          drop;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[10];

  // Single access from idle: strobes during the window, exact ready latency, returned data.
  task automatic apply_vec(input vec_t v);
    int k = v.lane;
    int n = 0;
    bit seen = 0;
    bit held = 1;
    if (v.is_d) begin
      d_we[k] = v.we; d_addr[k] = v.addr; d_wdata[k] = v.wdata; d_req[k] = 1'b1;
      if (v.we) ref_mem[k][v.addr[7:0]] = v.wdata;
    end else begin
      i_addr[k] = v.addr; i_req[k] = 1'b1;
    end
    while (!seen && n < 20) begin
      @(posedge clk); n++; #1;
      if (v.is_d ? d_ready[k] : i_ready[k]) begin
        seen = 1;
      end else begin
        chk($sformatf("vec L%0d rd strobe n%0d", k, n), mem_read[k], !(v.is_d && v.we));
        chk($sformatf("vec L%0d wr strobe n%0d", k, n), mem_write[k], v.is_d && v.we);
        chk($sformatf("vec L%0d mem_addr n%0d", k, n), mem_addr[k], v.addr);
        if (v.is_d && v.we) chk($sformatf("vec L%0d mem_wdata", k), mem_wdata[k], v.wdata);
        chk($sformatf("vec L%0d stall n%0d", k, n), v.is_d ? stall_mem[k] : stall_if[k], held);
        if (n == 1 && v.drop) begin
          held = 0;
          if (v.is_d) d_req[k] = 1'b0; else i_req[k] = 1'b0;
        end
      end
    end
    chk($sformatf("vec L%0d latency", k), n, lat_of(k) + 1);
    chk($sformatf("vec L%0d data", k), v.is_d ? d_rdata[k] : i_data[k], v.exp);
    chk($sformatf("vec L%0d other ready", k), v.is_d ? i_ready[k] : d_ready[k], 0);
    i_req[k] = 1'b0;
    d_req[k] = 1'b0;
  endtask

  // Both requesters held on lane 0 from reset: expect grants D, I, D, I.
  task automatic conflict_seq();
    string order = "";
    int n = 0, ni = 0, done = 0;
    i_addr[0] = 16'h0010; i_req[0] = 1'b1;
    d_we[0] = 1'b0; d_addr[0] = 16'h0030; d_req[0] = 1'b1;
    while (done < 4 && n < 60) begin
      @(posedge clk); n++; ni++; #1;
      chk("conflict both ready", i_ready[0] & d_ready[0], 0);
      if (d_ready[0]) begin
        order = {order, "D"};
        chk("conflict d_rdata", d_rdata[0], ref_mem[0][d_addr[0][7:0]]);
        d_addr[0] = d_addr[0] + 16'd1;
        done++;
      end
      if (i_ready[0]) begin
        order = {order, "I"};
        chk("conflict fetch wait", ni, (ni <= 2 * (lat_of(0) + 1)) ? ni : 2 * (lat_of(0) + 1));
        chk("conflict i_data", i_data[0], ref_mem[0][i_addr[0][7:0]]);
        i_addr[0] = i_addr[0] + 16'd1;
        ni = 0;
        done++;
      end
    end
    checks++;
    if (order != "DIDI") begin
      errors++;
      $display("FAIL conflict order: got %s expected DIDI", order);
    end
    i_req[0] = 1'b0;
    d_req[0] = 1'b0;
  endtask

  // Transaction-level model: the port is free or busy until a known edge; a free port
  // serves the sampled requests by the priority rule and completes exactly lat edges later.
  task automatic run_random(input int k, input int ncyc);
    int lat = lat_of(k);
    int done_edge = 0;
    bit busy = 0, cur_d = 0, cur_we = 0, last_d = 0, i_infl = 0, d_infl = 0;
    bit iv, dv, exp_ir, exp_dr, gnt;
    logic [15:0] cur_addr = '0, cur_data = '0, exp_i = '0, exp_d = '0;
    for (int t = 0; t < ncyc; t++) begin
      @(posedge clk);
      iv = i_req[k]; dv = d_req[k];
      exp_ir = 0; exp_dr = 0; gnt = 0;
      if (busy && t == done_edge) begin
        busy = 0;
        if (cur_d) begin
          exp_dr = 1; d_infl = 0;
          if (!cur_we) exp_d = cur_data;
        end else begin
          exp_ir = 1; i_infl = 0; exp_i = cur_data;
        end
      end else if (!busy && (iv || dv)) begin
        gnt = 1; busy = 1; done_edge = t + lat;
        cur_d = dv && (!iv || !last_d);
        last_d = cur_d;
        if (cur_d) begin
          cur_we = d_we[k]; cur_addr = d_addr[k]; d_infl = 1;
          if (cur_we) begin
            cur_data = d_wdata[k];
            ref_mem[k][cur_addr[7:0]] = cur_data;
          end else begin
            cur_data = ref_mem[k][cur_addr[7:0]];
          end
        end else begin
          cur_we = 0; cur_addr = i_addr[k]; i_infl = 1;
          cur_data = ref_mem[k][cur_addr[7:0]];
        end
      end
      #1;
      chk($sformatf("rnd L%0d t%0d i_ready", k, t), i_ready[k], exp_ir);
      chk($sformatf("rnd L%0d t%0d d_ready", k, t), d_ready[k], exp_dr);
      chk($sformatf("rnd L%0d t%0d stall_if", k, t), stall_if[k], iv & ~exp_ir);
      chk($sformatf("rnd L%0d t%0d stall_mem", k, t), stall_mem[k], dv & ~exp_dr);
      chk($sformatf("rnd L%0d t%0d mem_read", k, t), mem_read[k], busy && !cur_we);
      chk($sformatf("rnd L%0d t%0d mem_write", k, t), mem_write[k], busy && cur_we);
      if (busy) chk($sformatf("rnd L%0d t%0d mem_addr", k, t), mem_addr[k], cur_addr);
      if (busy && cur_we) chk($sformatf("rnd L%0d t%0d mem_wdata", k, t), mem_wdata[k], cur_data);
      if (exp_ir) chk($sformatf("rnd L%0d t%0d i_data", k, t), i_data[k], exp_i);
      if (exp_dr) chk($sformatf("rnd L%0d t%0d d_rdata", k, t), d_rdata[k], exp_d);
      if (exp_ir) i_req[k] = 1'b0;
      if (exp_dr) d_req[k] = 1'b0;
      if (gnt && $urandom_range(0, 3) == 0) begin
        if (cur_d) d_req[k] = 1'b0; else i_req[k] = 1'b0;
      end
      if (!i_req[k] && !i_infl && $urandom_range(0, 1) == 1) begin
        i_addr[k] = 16'($urandom_range(0, 15));
        i_req[k] = 1'b1;
      end
      if (!d_req[k] && !d_infl && $urandom_range(0, 1) == 1) begin
        d_addr[k] = 16'($urandom_range(0, 15));
        d_we[k] = 1'($urandom_range(0, 1));
        d_wdata[k] = 16'($urandom);
        d_req[k] = 1'b1;
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      i_req[k] = 1'b0; d_req[k] = 1'b0; d_we[k] = 1'b0;
      i_addr[k] = '0; d_addr[k] = '0; d_wdata[k] = '0;
      for (int a = 0; a < 256; a++) ref_mem[k][a] = mem_init(16'(a));
    end
    vecs[0] = '{lane: 0, is_d: 0, we: 0, drop: 0, addr: 16'h0010, wdata: 16'h0000, exp: 16'h6A05};
    vecs[1] = '{lane: 0, is_d: 1, we: 1, drop: 0, addr: 16'h0020, wdata: 16'hBEEF, exp: 16'h0000};
    vecs[2] = '{lane: 0, is_d: 1, we: 0, drop: 0, addr: 16'h0020, wdata: 16'h0000, exp: 16'hBEEF};
    vecs[3] = '{lane: 0, is_d: 0, we: 0, drop: 0, addr: 16'h0030, wdata: 16'h0000, exp: 16'h6A25};
    vecs[4] = '{lane: 1, is_d: 0, we: 0, drop: 1, addr: 16'h0040, wdata: 16'h0000, exp: 16'h6A35};
    vecs[5] = '{lane: 1, is_d: 1, we: 1, drop: 1, addr: 16'h0050, wdata: 16'h1234, exp: 16'h0000};
    vecs[6] = '{lane: 1, is_d: 1, we: 0, drop: 0, addr: 16'h0050, wdata: 16'h0000, exp: 16'h1234};
    vecs[7] = '{lane: 2, is_d: 0, we: 0, drop: 1, addr: 16'h0041, wdata: 16'h0000, exp: 16'h6A36};
    vecs[8] = '{lane: 2, is_d: 1, we: 1, drop: 1, addr: 16'h0007, wdata: 16'hCAFE, exp: 16'h0000};
    vecs[9] = '{lane: 2, is_d: 1, we: 0, drop: 0, addr: 16'h0007, wdata: 16'h0000, exp: 16'hCAFE};

    #2;
    for (int k = 0; k < 3; k++) chk_zero(k, "por");
    do_reset();
    repeat (3) begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("idle L%0d strobes", k), {mem_read[k], mem_write[k]}, 0);
        chk($sformatf("idle L%0d readies", k), {i_ready[k], d_ready[k]}, 0);
      end
    end

    foreach (vecs[i]) apply_vec(vecs[i]);

    do_reset();
    conflict_seq();

    for (int k = 0; k < 3; k++) begin
      do_reset();
      run_random(k, 400);
    end

    // Asynchronous reset in the middle of a store.
    do_reset();
    d_we[0] = 1'b1; d_addr[0] = 16'h0020; d_wdata[0] = 16'h5555; d_req[0] = 1'b1;
    @(posedge clk); #1;
    chk("midrst mem_write before", mem_write[0], 1);
    #2 reset_n = 1'b0;
    d_req[0] = 1'b0;
    #1;
    chk_zero(0, "midrst");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      chk("post-rst strobes", {mem_read[0], mem_write[0]}, 0);
      chk("post-rst d_ready", d_ready[0], 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
